usb_utm_rx_deser: RTL and testbench

- RX deserializer stage of the FS-only UTM, directly downstream of the NRZI decoder / bit unstuffer.
- Consumes one decoded bit per bit-time strobe, detects SYNC, assembles LSB-first bytes, detects EOP and reports bit-stuff errors.
- Drives the UTMI receive side (rx_data / rx_valid / rx_active / rx_error) toward the SIE.

---
 rtl/usb_utm_rx_deser_if.sv | 26 ++
 rtl/usb_utm_rx_deser.sv | 178 +++++++++++++++++
 tb/tb_usb_utm_rx_deser.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_utm_rx_deser_if.sv
// Bit-level input bus from the NRZI decoder / unstuffer and the UTMI receive
// outputs toward the SIE, bundled for the FS RX deserializer.
interface usb_utm_rx_deser_if;
    logic       bit_strobe;
    logic       bit_data;
    logic       bit_stuffed;
    logic       stuff_err;
    logic       line_se0;
    logic       line_j;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    // Upstream side: supplies decoded bits, observes the UTMI receive outputs.
    modport master (
        output bit_strobe, bit_data, bit_stuffed, stuff_err, line_se0, line_j,
        input  rx_data, rx_valid, rx_active, rx_error
    );

    // Deserializer side.
    modport slave (
        input  bit_strobe, bit_data, bit_stuffed, stuff_err, line_se0, line_j,
        output rx_data, rx_valid, rx_active, rx_error
    );
endinterface

// File: rtl/usb_utm_rx_deser.sv
// FS UTM receive deserializer: SYNC detection, LSB-first byte assembly,
// EOP detection and bit-stuff error reporting toward the SIE.
module usb_utm_rx_deser #(
    parameter int unsigned SYNC_MIN_ZEROS = 4,
    parameter int unsigned EOP_TIMEOUT    = 8,
    parameter int unsigned ERR_IDLE_BITS  = 8
) (
    input logic               clk,
    input logic               rst,
    usb_utm_rx_deser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_WAIT,
        S_ERR_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] zero_cnt_q, zero_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] eop_cnt_q, eop_cnt_d;
    logic [3:0] j_run_q, j_run_d;
    logic       prev_se0_q, prev_se0_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_active_q, rx_active_d;
    logic       rx_error_q, rx_error_d;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values computed by the combinational process.
        if (rst) begin
            state_q     <= S_IDLE;
            zero_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            eop_cnt_q   <= '0;
            j_run_q     <= '0;
            prev_se0_q  <= 1'b0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_cnt_q  <= zero_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            eop_cnt_q   <= eop_cnt_d;
            j_run_q     <= j_run_d;
            prev_se0_q  <= prev_se0_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    always_comb begin
        // NOTE: every output of this process is defaulted first, so no path
        // through the case statement can leave a variable unassigned (no latches).
        state_d    = state_q;
        zero_cnt_d = zero_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        eop_cnt_d  = eop_cnt_q;
        j_run_d    = j_run_q;
        prev_se0_d = prev_se0_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;

        if (bus.bit_strobe) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.line_se0 && !bus.bit_data) begin
                        state_d    = S_SYNC;
                        zero_cnt_d = 3'd1;
                    end
                end

                S_SYNC: begin
                    if (bus.line_se0) begin
                        state_d = S_IDLE;
                    end else if (bus.bit_stuffed) begin
                        state_d = S_SYNC;
                    end else if (!bus.bit_data) begin
                        if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
                    end else if (zero_cnt_q >= 3'(SYNC_MIN_ZEROS)) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_DATA: begin
                    if (bus.line_se0) begin
                        // Any partially assembled byte at EOP is a framing error.
                        state_d    = S_EOP_WAIT;
                        eop_cnt_d  = 4'd1;
                        rx_error_d = (bit_cnt_q != 3'd0);
                        bit_cnt_d  = 3'd0;
                    end else if (bus.stuff_err) begin
                        state_d    = S_ERR_WAIT;
                        rx_error_d = 1'b1;
                        bit_cnt_d  = 3'd0;
                        j_run_d    = 4'd0;
                        prev_se0_d = 1'b0;
                    end else if (!bus.bit_stuffed) begin
                        shreg_d   = {bus.bit_data, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shreg_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                end

                S_EOP_WAIT: begin
                    if (bus.line_se0) begin
                        if ({1'b0, eop_cnt_q} + 5'd1 >= 5'(EOP_TIMEOUT)) begin
                            state_d    = S_IDLE;
                            rx_error_d = 1'b1;
                            eop_cnt_d  = 4'd0;
                        end else begin
                            eop_cnt_d = eop_cnt_q + 4'd1;
                        end
                    end else if (bus.line_j) begin
                        state_d   = S_IDLE;
                        eop_cnt_d = 4'd0;
                    end else begin
                        state_d    = S_ERR_WAIT;
                        rx_error_d = 1'b1;
                        eop_cnt_d  = 4'd0;
                        j_run_d    = 4'd0;
                        prev_se0_d = 1'b0;
                    end
                end

                S_ERR_WAIT: begin
                    // Leave on an SE0->J edge or on a long enough run of idle J.
                    if (bus.line_se0) begin
                        prev_se0_d = 1'b1;
                        j_run_d    = 4'd0;
                    end else if (bus.line_j) begin
                        prev_se0_d = 1'b0;
                        if (prev_se0_q ||
                            ({1'b0, j_run_q} + 5'd1 >= 5'(ERR_IDLE_BITS))) begin
                            state_d = S_IDLE;
                            j_run_d = 4'd0;
                        end else begin
                            j_run_d = j_run_q + 4'd1;
                        end
                    end else begin
                        prev_se0_d = 1'b0;
                        j_run_d    = 4'd0;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end

        rx_active_d = (state_d == S_DATA) || (state_d == S_EOP_WAIT) ||
                      (state_d == S_ERR_WAIT);
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_active = rx_active_q;
    assign bus.rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_utm_rx_deser.sv
// Directed bench for usb_utm_rx_deser: expected bytes go into a scoreboard queue
// as they are sent and are popped by a monitor when rx_valid pulses.
module tb_usb_utm_rx_deser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_utm_rx_deser_if bus ();

    usb_utm_rx_deser #(
        .SYNC_MIN_ZEROS(4),
        .EOP_TIMEOUT   (8),
        .ERR_IDLE_BITS (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         err_seen = 0;
    int         err_exp  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: counts error pulses and scores every delivered byte.
    always @(negedge clk) begin
        if (bus.rx_error) err_seen++;
        if (bus.rx_valid) begin
            check("valid_with_active", 8'(bus.rx_active), 8'd1);
            check("valid_without_error", 8'(bus.rx_error), 8'd0);
            checks++;
            assert (exp_q.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_byte observed=%0h expected=none", bus.rx_data);
            end
            if (exp_q.size() > 0) check("rx_data", bus.rx_data, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One bit time: strobe held one clock, outputs settled when the task returns.
    task automatic strobe(input logic d, input logic stuffed, input logic serr,
                          input logic se0, input logic j);
        repeat (2) @(posedge clk);
        #1;
        bus.bit_strobe  = 1'b1;
        bus.bit_data    = d;
        bus.bit_stuffed = stuffed;
        bus.stuff_err   = serr;
        bus.line_se0    = se0;
        bus.line_j      = j;
        @(posedge clk);
        #1;
        bus.bit_strobe  = 1'b0;
        bus.bit_stuffed = 1'b0;
        bus.stuff_err   = 1'b0;
        bus.line_se0    = 1'b0;
        bus.line_j      = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic d);
        strobe(d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_se0();
        strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_j();
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_sync(input int zeros);
        repeat (zeros) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    // Sends b LSB-first; a stuff bit follows bit index stuff_after (-1: none).
    task automatic send_byte(input logic [7:0] b, input int stuff_after);
        exp_q.push_back(b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (i == stuff_after) strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] partial;

        rst             = 1'b1;
        bus.bit_strobe  = 1'b0;
        bus.bit_data    = 1'b0;
        bus.bit_stuffed = 1'b0;
        bus.stuff_err   = 1'b0;
        bus.line_se0    = 1'b0;
        bus.line_j      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_valid", 8'(bus.rx_valid), 8'd0);
        check("reset_rx_active", 8'(bus.rx_active), 8'd0);
        check("reset_rx_error", 8'(bus.rx_error), 8'd0);
        rst = 1'b0;

        // Full SYNC, one byte, normal EOP.
        repeat (7) send_bit(1'b0);
        check("sync_before_one_inactive", 8'(bus.rx_active), 8'd0);
        send_bit(1'b1);
        check("sync_active_rise", 8'(bus.rx_active), 8'd1);
        send_byte(8'hA5, -1);
        send_se0();
        check("eop_se0_active", 8'(bus.rx_active), 8'd1);
        send_se0();
        send_j();
        check("eop_j_active_fall", 8'(bus.rx_active), 8'd0);
        check("a5_rx_data_held", bus.rx_data, 8'hA5);
        check("a5_no_error", 8'(err_seen), 8'(err_exp));

        // Stuffed bit after six ones is discarded.
        send_sync(4);
        send_byte(8'hFF, 5);
        send_se0();
        send_se0();
        send_j();
        check("ff_queue_drained", 8'(exp_q.size()), 8'd0);
        check("ff_rx_data", bus.rx_data, 8'hFF);
        check("ff_no_error", 8'(err_seen), 8'(err_exp));

        // Short SYNC (2 zeros) is rejected; following bits never qualify.
        send_sync(2);
        check("short_sync_inactive", 8'(bus.rx_active), 8'd0);
        partial = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(partial[i]);
        send_j();
        check("short_sync_still_inactive", 8'(bus.rx_active), 8'd0);

        // Stuff error mid second byte, exit through SE0 then J.
        send_sync(4);
        send_byte(8'h5A, -1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        err_exp++;
        check("stuff_err_pulse", 8'(err_seen), 8'(err_exp));
        check("stuff_err_active_held", 8'(bus.rx_active), 8'd1);
        send_se0();
        check("err_wait_se0_active", 8'(bus.rx_active), 8'd1);
        send_j();
        check("err_wait_se0_j_exit", 8'(bus.rx_active), 8'd0);
        check("stuff_err_rx_data_kept", bus.rx_data, 8'h5A);

        // Stuff error, exit through a run of idle J.
        send_sync(4);
        send_byte(8'h3C, -1);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        err_exp++;
        repeat (7) send_j();
        check("j_run_7_active", 8'(bus.rx_active), 8'd1);
        send_j();
        check("j_run_8_exit", 8'(bus.rx_active), 8'd0);
        check("j_run_errors", 8'(err_seen), 8'(err_exp));

        // SE0 after three bits: partial byte dropped with an error.
        send_sync(4);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_se0();
        err_exp++;
        check("partial_eop_error", 8'(err_seen), 8'(err_exp));
        check("partial_eop_active", 8'(bus.rx_active), 8'd1);
        send_se0();
        send_j();
        check("partial_eop_fall", 8'(bus.rx_active), 8'd0);

        // K during EOP_WAIT.
        send_sync(4);
        send_byte(8'h96, -1);
        send_se0();
        strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        err_exp++;
        check("eop_k_error", 8'(err_seen), 8'(err_exp));
        check("eop_k_active", 8'(bus.rx_active), 8'd1);
        send_se0();
        send_j();
        check("eop_k_exit", 8'(bus.rx_active), 8'd0);

        // SE0 held without J: timeout on the eighth SE0 strobe.
        send_sync(4);
        send_byte(8'h0F, -1);
        repeat (7) send_se0();
        check("timeout_7_active", 8'(bus.rx_active), 8'd1);
        check("timeout_7_no_error", 8'(err_seen), 8'(err_exp));
        send_se0();
        err_exp++;
        check("timeout_8_error", 8'(err_seen), 8'(err_exp));
        check("timeout_8_inactive", 8'(bus.rx_active), 8'd0);

        // Reset coinciding with the eighth bit of a byte: no pulse, all clear.
        send_sync(4);
        partial = 8'h81;
        for (int i = 0; i < 7; i++) send_bit(partial[i]);
        repeat (2) @(posedge clk);
        #1;
        bus.bit_strobe = 1'b1;
        bus.bit_data   = 1'b1;
        rst            = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_strobe = 1'b0;
        check("rst_mid_rx_data", bus.rx_data, 8'h00);
        check("rst_mid_rx_valid", 8'(bus.rx_valid), 8'd0);
        check("rst_mid_rx_active", 8'(bus.rx_active), 8'd0);
        check("rst_mid_rx_error", 8'(bus.rx_error), 8'd0);
        rst = 1'b0;
        send_j();
        check("after_rst_idle", 8'(bus.rx_active), 8'd0);

        check("final_queue_empty", 8'(exp_q.size()), 8'd0);
        check("final_error_count", 8'(err_seen), 8'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
